// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-nibble ALU sequencer: FSM states, op codes, nibble width.
package alu_seq_pkg;
   localparam int NW = 4;

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_INV, S_DONE} state_t;

   // arithmetic ops (l=0)
   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_NEG  = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_NOTB = 2'b11;
   // logic ops (l=1)
   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NOTA = 2'b11;
endpackage

// File: rtl/alu.sv
// 4-bit ALU: arithmetic inc/neg/add/notb with carry, logic and/or/xor/nota (carry 0).
module alu
   import alu_seq_pkg::*;
(
   input  logic [NW-1:0] A,
   input  logic [NW-1:0] B,
   input  logic          cin,
   input  logic [1:0]    Op,
   input  logic          l,
   output logic [NW-1:0] R,
   output logic          cout
);
   logic [NW:0] w_sum;
   logic [NW:0] w_ci;

   assign w_ci = {{NW{1'b0}}, cin};

   always_comb begin
      w_sum = '0;
      if (l) begin
         case (Op)
            OP_AND:  w_sum = {1'b0, A & B};
            OP_OR:   w_sum = {1'b0, A | B};
            OP_XOR:  w_sum = {1'b0, A ^ B};
            default: w_sum = {1'b0, ~A};
         endcase
      end else begin
         case (Op)
            OP_INC:  w_sum = {1'b0, A} + w_ci;
            // two's complement negate: ~A + 1, then the carry-in on top
            OP_NEG:  w_sum = {1'b0, ~A} + {{NW{1'b0}}, 1'b1} + w_ci;
            OP_ADD:  w_sum = {1'b0, A} + {1'b0, B} + w_ci;
            default: w_sum = {1'b0, ~B} + w_ci;
         endcase
      end
   end

   assign R    = w_sum[NW-1:0];
   assign cout = w_sum[NW];
endmodule

// File: rtl/alu_seq.sv
// W-bit (4*NIB) operation sequenced nibble-by-nibble through one 4-bit alu, with valid/ready on both sides.
// Optional signed-overflow flag output v when ALU_SEQ_OVF_EN is defined.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int NIB = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*NIB-1:0] A,
   input  logic [4*NIB-1:0] B,
   input  logic            cin,
   input  logic [1:0]      Op,
   input  logic            l,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*NIB-1:0] R,
   output logic            z,
   output logic            c,
   output logic            s
`ifdef ALU_SEQ_OVF_EN
   ,
   output logic            v
`endif
);
   localparam int W  = NW * NIB;
   localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic [W-1:0]    r_a, r_b, r_acc, r_R;
   logic [1:0]      r_op;
   logic            r_cin, r_l, r_carry;
   logic [NW-1:0]   r_tmp;
   logic            r_in_ready, r_out_valid, r_z, r_c, r_s;

   logic [NW-1:0]   w_a, w_b, w_alu_r;
   logic [1:0]      w_op;
   logic            w_l, w_cin, w_alu_c, w_neg, w_last;
   logic [W-1:0]    w_res;

   assign w_neg  = ~r_l & (r_op == OP_NEG);
   assign w_last = (r_idx == IW'(NIB - 1));

   // Upper negate nibbles are ~A_i (INV pass into r_tmp) followed by r_tmp + carry.
   always_comb begin
      w_a   = r_a[r_idx*NW +: NW];
      w_b   = r_b[r_idx*NW +: NW];
      w_op  = r_op;
      w_l   = r_l;
      w_cin = (r_idx == '0) ? r_cin : r_carry;
      if (r_state == S_INV) begin
         w_op = OP_NOTA;
         w_l  = 1'b1;
      end else if (w_neg && r_idx != '0) begin
         w_a  = r_tmp;
         w_b  = '0;
         w_op = OP_INC;
         w_l  = 1'b0;
      end
   end

   alu u_alu (
      .A    (w_a),
      .B    (w_b),
      .cin  (w_cin),
      .Op   (w_op),
      .l    (w_l),
      .R    (w_alu_r),
      .cout (w_alu_c)
   );

   always_comb begin
      w_res = r_acc;
      w_res[r_idx*NW +: NW] = w_alu_r;
   end

`ifdef ALU_SEQ_OVF_EN
   logic r_v, w_v;
   always_comb begin
      w_v = 1'b0;
      if (!r_l) begin
         case (r_op)
            OP_ADD:  w_v = (r_a[W-1] == r_b[W-1]) & (w_res[W-1] != r_a[W-1]);
            OP_INC:  w_v = ~r_a[W-1] & w_res[W-1];
            OP_NEG:  w_v = r_a[W-1] & w_res[W-1];
            default: w_v = r_b[W-1] & w_res[W-1];
         endcase
      end
   end
   assign v = r_v;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_R         <= '0;
         r_op        <= '0;
         r_cin       <= 1'b0;
         r_l         <= 1'b0;
         r_carry     <= 1'b0;
         r_tmp       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_s         <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
         r_v         <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_a        <= A;
               r_b        <= B;
               r_cin      <= cin;
               r_op       <= Op;
               r_l        <= l;
               r_idx      <= '0;
               r_acc      <= '0;
               r_in_ready <= 1'b0;
               r_state    <= S_PASS;
            end
            S_PASS: begin
               r_acc[r_idx*NW +: NW] <= w_alu_r;
               r_carry <= w_alu_c;
               if (w_last) begin
                  r_R         <= w_res;
                  r_z         <= (w_res == '0);
                  r_c         <= w_alu_c;
                  r_s         <= w_res[W-1];
`ifdef ALU_SEQ_OVF_EN
                  r_v         <= w_v;
`endif
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= w_neg ? S_INV : S_PASS;
               end
            end
            S_INV: begin
               r_tmp   <= w_alu_r;
               r_state <= S_PASS;
            end
            default: if (out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign R         = r_R;
   assign z         = r_z;
   assign c         = r_c;
   assign s         = r_s;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (NIB=2): directed scenarios plus random ops vs a W-bit arithmetic model.
module tb_alu_seq;
   localparam int NIB = 2;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0, reset = 1'b1;
   logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0, l = 1'b0;
   logic [1:0]   Op = 2'b00;
   logic [W-1:0] A = '0, B = '0;
   logic         in_ready, out_valid, z, c, s;
   logic [W-1:0] R;
`ifdef ALU_SEQ_OVF_EN
   logic         v;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.NIB(NIB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .cin(cin), .Op(Op), .l(l),
      .out_valid(out_valid), .out_ready(out_ready),
      .R(R), .z(z), .c(c), .s(s)
`ifdef ALU_SEQ_OVF_EN
      , .v(v)
`endif
   );

   // Reference: whole-word arithmetic, no nibble view.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [1:0] op, input logic lg,
                        output logic [W-1:0] r, output logic ez, output logic ec,
                        output logic es, output logic ev, output int p);
      logic [W:0] sum;
      sum = '0;
      ev  = 1'b0;
      if (lg) begin
         case (op)
            2'b00: sum = {1'b0, a & b};
            2'b01: sum = {1'b0, a | b};
            2'b10: sum = {1'b0, a ^ b};
            default: sum = {1'b0, ~a};
         endcase
      end else begin
         case (op)
            2'b00: sum = a + ci;
            2'b01: sum = {1'b0, ~a} + 1 + ci;
            2'b10: sum = a + b + ci;
            default: sum = {1'b0, ~b} + ci;
         endcase
      end
      r  = sum[W-1:0];
      ec = lg ? 1'b0 : sum[W];
      ez = (r == 0);
      es = r[W-1];
      if (!lg) begin
         case (op)
            2'b10: ev = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            2'b00: ev = !a[W-1] && r[W-1];
            2'b01: ev = a[W-1] && r[W-1];
            default: ev = b[W-1] && r[W-1];
         endcase
      end
      p = (!lg && op == 2'b01) ? 1 + 2 * (NIB - 1) : NIB;
   endtask

   // Issue one request, return the number of edges from accept until out_valid is seen.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [1:0] op, input logic lg, output int lat);
      @(negedge clk);
      A = a; B = b; cin = ci; Op = op; l = lg; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic get_v();
`ifdef ALU_SEQ_OVF_EN
      return v;
`else
      return 1'b0;
`endif
   endfunction

   // Run one op, compare result bundle and latency against the model, then handshake.
   task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic [1:0] op, input logic lg);
      logic [W-1:0] er;
      logic ez, ec, es, ev;
      int p, lat;
      model(a, b, ci, op, lg, er, ez, ec, es, ev, p);
      send(a, b, ci, op, lg, lat);
      checks++;
      if (lat !== p) begin
         errors++;
         $display("FAIL %s latency got %0d exp %0d", name, lat, p);
      end
      checks++;
      if ({R, z, c, s} !== {er, ez, ec, es}) begin
         errors++;
         $display("FAIL %s R/z/c/s got %h/%b%b%b exp %h/%b%b%b", name, R, z, c, s, er, ez, ec, es);
      end
`ifdef ALU_SEQ_OVF_EN
      checks++;
      if (get_v() !== ev) begin
         errors++;
         $display("FAIL %s v got %b exp %b", name, get_v(), ev);
      end
`endif
      take();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, R, z, c, s, get_v()} !== {1'b1, 1'b0, {W{1'b0}}, 4'b0000}) begin
         errors++;
         $display("FAIL reset rdy/vld/R/zcsv got %b/%b/%h/%b%b%b%b exp 1/0/00/0000",
                  in_ready, out_valid, R, z, c, s, get_v());
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      run_check("add_8F_71", 8'h8F, 8'h71, 1'b0, 2'b10, 1'b0);
      run_check("inc_FF", 8'hFF, 8'h00, 1'b1, 2'b00, 1'b0);
   endtask

   task automatic test_negate();
      run_check("neg_00", 8'h00, 8'h00, 1'b0, 2'b01, 1'b0);
      run_check("neg_01", 8'h01, 8'h00, 1'b0, 2'b01, 1'b0);
      run_check("neg_80", 8'h80, 8'h00, 1'b0, 2'b01, 1'b0);
   endtask

   task automatic test_notb_ovf();
      run_check("notb_0F", 8'h00, 8'h0F, 1'b1, 2'b11, 1'b0);
      run_check("ovf_7F_01", 8'h7F, 8'h01, 1'b0, 2'b10, 1'b0);
   endtask

   task automatic test_logic();
      run_check("xor_A5_FF", 8'hA5, 8'hFF, 1'b1, 2'b10, 1'b1);
      run_check("and_F0_3C", 8'hF0, 8'h3C, 1'b1, 2'b00, 1'b1);
      run_check("nota_00", 8'h00, 8'h55, 1'b0, 2'b11, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] er;
      logic ez, ec, es, ev;
      int p, lat;
      model(8'h3C, 8'h4D, 1'b1, 2'b10, 1'b0, er, ez, ec, es, ev, p);
      send(8'h3C, 8'h4D, 1'b1, 2'b10, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         A = 8'h11; B = 8'h22; Op = 2'b10; l = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, R, z, c, s} !== {1'b1, 1'b0, er, ez, ec, es}) begin
            errors++;
            $display("FAIL bp_hold[%0d] vld/rdy/R/zcs got %b/%b/%h/%b%b%b exp 1/0/%h/%b%b%b",
                     i, out_valid, in_ready, R, z, c, s, er, ez, ec, es);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      take();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release vld/rdy got %b/%b exp 0/1", out_valid, in_ready);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_phantom out_valid got %b exp 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      A = 8'h37; B = 8'h00; cin = 1'b0; Op = 2'b01; l = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL rst_mid rdy/vld got %b/%b exp 1/0", in_ready, out_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_aborted out_valid got %b exp 0", out_valid);
      end
      run_check("add_after_rst", 8'h12, 8'h34, 1'b1, 2'b10, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++)
         run_check("rand", W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
   endtask

   initial begin
      test_reset();
      test_add();
      test_negate();
      test_notb_ovf();
      test_logic();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
